// File: rtl/seven_seg_scan_ctrl_if.sv
// Load handshake between a value producer and the seven-segment scan controller.
// The producer offers a BCD value and sign; the controller accepts it while ready is high.
interface seven_seg_scan_ctrl_if;
    logic        load;
    logic [15:0] value_bcd;
    logic        neg;
    logic        ready;

    modport master (output load, output value_bcd, output neg, input ready);
    modport slave  (input load, input value_bcd, input neg, output ready);
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with leading-zero blanking, minus sign
// placement and a double-buffered load path that only swaps values on frame boundaries.
module seven_seg_scan_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter int GAP         = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    seven_seg_scan_ctrl_if.slave bus,
    output logic [3:0]           bcd_op,
    input  logic [6:0]           seg_in,
    output logic [6:0]           seg_out,
    output logic [3:0]           an,
    output logic                 sign_lost
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 2;
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_GAP   = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       idx, idx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       an_nxt;
    logic [6:0]       seg_nxt;
    logic             frame_start;

    logic             pend_full;
    logic [15:0]      pend_val;
    logic             pend_neg;
    logic [15:0]      disp_val;
    logic             disp_neg;

    logic [4:0]       digit;
    logic [6:0]       drive_seg;
    logic [3:0]       drive_an;
    logic             load_take;

    // Returns {show, code}: show=0 means the digit is blanked.
    // The minus sign sits just left of the leftmost significant digit.
    function automatic logic [4:0] digit_sel(input logic [15:0] v,
                                             input logic        n,
                                             input logic [1:0]  i);
        int         lead;
        logic [3:0] nib;
        lead = 0;
        for (int k = 1; k < 4; k++) begin
            if (v[4*k +: 4] != 4'h0) lead = k;
        end
        nib = v[{i, 2'b00} +: 4];
        if (int'(i) <= lead)                 return {1'b1, nib};
        else if (n && (int'(i) == lead + 1)) return {1'b1, 4'hF};
        else                                 return 5'b0_0000;
    endfunction

    assign digit     = digit_sel(disp_val, disp_neg, idx);
    assign bcd_op    = digit[3:0];
    assign drive_seg = digit[4] ? seg_in : 7'b111_1111;
    assign drive_an  = 4'b1111 & ~(4'b0001 << idx);
    assign bus.ready = ~pend_full;
    assign load_take = bus.load & ~pend_full;

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        cnt_nxt     = cnt;
        an_nxt      = 4'b1111;
        seg_nxt     = 7'b111_1111;
        frame_start = 1'b0;
        if (!en) begin
            state_nxt = S_OFF;
            idx_nxt   = 2'd0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_OFF: begin
                    state_nxt   = S_GAP;
                    idx_nxt     = 2'd0;
                    cnt_nxt     = '0;
                    frame_start = 1'b1;
                end
                S_GAP: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == GAP_LAST) begin
                        state_nxt = S_DRIVE;
                        an_nxt    = drive_an;
                        seg_nxt   = drive_seg;
                    end
                end
                S_DRIVE: begin
                    if (cnt == DIV_LAST) begin
                        state_nxt   = S_GAP;
                        cnt_nxt     = '0;
                        idx_nxt     = idx + 2'd1;
                        frame_start = (idx == 2'd3);
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                        an_nxt  = drive_an;
                        seg_nxt = drive_seg;
                    end
                end
                default: begin
                    state_nxt = S_OFF;
                    idx_nxt   = 2'd0;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_GAP;
            idx       <= 2'd0;
            cnt       <= '0;
            an        <= 4'b1111;
            seg_out   <= 7'b111_1111;
            pend_full <= 1'b0;
            disp_val  <= 16'h0000;
            disp_neg  <= 1'b0;
            sign_lost <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            an      <= an_nxt;
            seg_out <= seg_nxt;
            // A full pending slot moves to the display only at a frame boundary.
            if (frame_start && pend_full) begin
                pend_full <= 1'b0;
                disp_val  <= pend_val;
                disp_neg  <= pend_neg;
                sign_lost <= pend_neg & (pend_val[15:12] != 4'h0);
            end else if (load_take) begin
                pend_full <= 1'b1;
            end
        end
    end

    // Pending data needs no reset; pend_full alone says whether it is valid.
    always_ff @(posedge clk) begin
        if (load_take) begin
            pend_val <= bus.value_bcd;
            pend_neg <= bus.neg;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with REFRESH_DIV=8, GAP=2 and a behavioural
// BCD-to-seven-segment decoder closing the bcd_op/seg_in loop.
module tb_seven_seg_scan_ctrl;

    logic       clk;
    logic       reset;
    logic       en;
    logic [3:0] bcd_op;
    logic [6:0] seg_in;
    logic [6:0] seg_out;
    logic [3:0] an;
    logic       sign_lost;

    int checks;
    int errors;

    seven_seg_scan_ctrl_if bus();

    seven_seg_scan_ctrl #(.REFRESH_DIV(8), .GAP(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .bus       (bus),
        .bcd_op    (bcd_op),
        .seg_in    (seg_in),
        .seg_out   (seg_out),
        .an        (an),
        .sign_lost (sign_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-low segments, bit 6 = a ... bit 0 = g; A..F show a dash.
    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'h0:    return 7'b0000001;
            4'h1:    return 7'b1001111;
            4'h2:    return 7'b0010010;
            4'h3:    return 7'b0000110;
            4'h4:    return 7'b1001100;
            4'h5:    return 7'b0100100;
            4'h6:    return 7'b0100000;
            4'h7:    return 7'b0001111;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0000100;
            default: return 7'b1111110;
        endcase
    endfunction

    always_comb seg_in = dec7(bcd_op);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic n);
        bus.load      = 1'b1;
        bus.value_bcd = v;
        bus.neg       = n;
        tick();
        bus.load      = 1'b0;
        check("ready_after_load", 32'(bus.ready), 32'd0);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 64 && !bus.ready; i++) tick();
        check("ready_rise", 32'(bus.ready), 32'd1);
        check("an_at_boundary", 32'(an), 32'hF);
    endtask

    task automatic wait_an(input logic [3:0] target);
        for (int i = 0; i < 64 && an !== target; i++) tick();
        check("an_wait", 32'(an), 32'(target));
    endtask

    // segs = {d3,d2,d1,d0} seven-bit patterns, bcds = {d3,d2,d1,d0} codes.
    task automatic check_frame(input logic [27:0] segs, input logic [15:0] bcds);
        for (int d = 0; d < 4; d++) begin
            logic [3:0] tgt;
            tgt = 4'b1111 & ~(4'b0001 << d);
            wait_an(tgt);
            check($sformatf("seg_d%0d", d), 32'(seg_out), 32'(segs[7*d +: 7]));
            check($sformatf("bcd_d%0d", d), 32'(bcd_op), 32'(bcds[4*d +: 4]));
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        en            = 1'b1;
        bus.load      = 1'b0;
        bus.value_bcd = 16'h0000;
        bus.neg       = 1'b0;
        @(negedge clk);
        tick();
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg_out), 32'h7F);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_sign_lost", 32'(sign_lost), 32'd0);
        reset = 1'b0;

        // One full 32-cycle scan period of the reset value "0".
        for (int c = 0; c < 32; c++) begin
            int         slot, pos;
            logic [3:0] exp_an;
            logic [6:0] exp_seg;
            slot    = c / 8;
            pos     = c % 8;
            exp_an  = (pos < 2) ? 4'hF : (4'b1111 & ~(4'b0001 << slot));
            exp_seg = (exp_an == 4'b1110) ? 7'b0000001 : 7'b1111111;
            check($sformatf("scan_an_c%0d", c), 32'(an), 32'(exp_an));
            check($sformatf("scan_seg_c%0d", c), 32'(seg_out), 32'(exp_seg));
            tick();
        end

        // Mid-frame load of 0042; old value stays until the boundary.
        repeat (4) tick();
        do_load(16'h0042, 1'b0);
        wait_an(4'b1101);
        check("old_d1_seg", 32'(seg_out), 32'h7F);
        wait_ready();
        check_frame({7'b1111111, 7'b1111111, 7'b1001100, 7'b0010010}, 16'h0042);
        check("sign_lost_0042", 32'(sign_lost), 32'd0);

        // Negative 7: minus on digit 1.
        do_load(16'h0007, 1'b1);
        wait_ready();
        check("sign_lost_n7", 32'(sign_lost), 32'd0);
        check_frame({7'b1111111, 7'b1111111, 7'b1111110, 7'b0001111}, 16'h00F7);

        // Negative 1234: no room for the sign.
        do_load(16'h1234, 1'b1);
        wait_ready();
        check("sign_lost_n1234", 32'(sign_lost), 32'd1);
        check_frame({7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 16'h1234);

        // Negative zero shows "-0".
        do_load(16'h0000, 1'b1);
        wait_ready();
        check("sign_lost_n0", 32'(sign_lost), 32'd0);
        check_frame({7'b1111111, 7'b1111111, 7'b1111110, 7'b0000001}, 16'h00F0);

        // Non-decimal nibble counts as significant and passes through.
        do_load(16'h0A05, 1'b0);
        wait_ready();
        check_frame({7'b1111111, 7'b1111110, 7'b0000001, 7'b0100100}, 16'h0A05);

        // Second load while busy is ignored.
        do_load(16'h0042, 1'b0);
        bus.load      = 1'b1;
        bus.value_bcd = 16'h9999;
        bus.neg       = 1'b0;
        tick();
        bus.load      = 1'b0;
        check("ready_still_low", 32'(bus.ready), 32'd0);
        wait_ready();
        check_frame({7'b1111111, 7'b1111111, 7'b1001100, 7'b0010010}, 16'h0042);

        // Disable for three cycles, loading while off; transfer on re-enable.
        en = 1'b0;
        tick();
        check("off_an_1", 32'(an), 32'hF);
        check("off_seg_1", 32'(seg_out), 32'h7F);
        bus.load      = 1'b1;
        bus.value_bcd = 16'h0007;
        bus.neg       = 1'b0;
        tick();
        bus.load      = 1'b0;
        check("off_an_2", 32'(an), 32'hF);
        check("off_load_ready", 32'(bus.ready), 32'd0);
        tick();
        check("off_an_3", 32'(an), 32'hF);
        en = 1'b1;
        tick();
        check("reen_ready", 32'(bus.ready), 32'd1);
        check("reen_an_0", 32'(an), 32'hF);
        tick();
        check("reen_an_1", 32'(an), 32'hF);
        tick();
        check("reen_an_2", 32'(an), 32'hE);
        check("reen_seg", 32'(seg_out), 32'(7'b0001111));
        check("reen_bcd", 32'(bcd_op), 32'h7);

        // Reset during digit 2 drive with a load pending and sign_lost set.
        do_load(16'h1234, 1'b1);
        wait_ready();
        check("pre_rst_sign_lost", 32'(sign_lost), 32'd1);
        do_load(16'h0042, 1'b1);
        wait_an(4'b1011);
        reset = 1'b1;
        tick();
        check("mid_rst_an", 32'(an), 32'hF);
        check("mid_rst_seg", 32'(seg_out), 32'h7F);
        check("mid_rst_ready", 32'(bus.ready), 32'd1);
        check("mid_rst_sign_lost", 32'(sign_lost), 32'd0);
        reset = 1'b0;
        check_frame({7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 16'h0000);
        check("post_rst_ready", 32'(bus.ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
